// File: rtl/w0rm_alu_result_queue.sv
// In-order result queue between the W0RM ALU units and register-file writeback.
// Buffers {data, dest, flags, flags_update} per result and commits the
// architectural flags register in program order as entries are written back.
module w0rm_alu_result_queue #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_result_valid,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic [3:0]                    alu_result_flags,
  input  logic [REG_ADDR_WIDTH-1:0]     alu_dest,
  input  logic                          alu_flags_update,
  output logic                          issue_ready,
  output logic                          wb_valid,
  output logic [DATA_WIDTH-1:0]         wb_data,
  output logic [REG_ADDR_WIDTH-1:0]     wb_dest,
  input  logic                          wb_ready,
  output logic [3:0]                    flags,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic [3:0]                flags;
    logic                      flags_update;
  } entry_t;

  entry_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_flags;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  entry_t            w_head;
  entry_t            w_new;

  // Handshake qualifiers, all derived from registered occupancy
  always_comb begin
    w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    w_empty = (r_count == CNT_W'(0));
    w_push  = alu_result_valid && !w_full;
    w_pop   = !w_empty && wb_ready;
    w_head  = r_mem[r_rd_ptr];
    w_new   = '{data:         alu_result,
                dest:         alu_dest,
                flags:        alu_result_flags,
                flags_update: alu_flags_update};
  end

  // Entry storage; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Architectural flags commit at writeback of a flag-updating entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'h0;
    end else if (w_pop && w_head.flags_update) begin
      r_flags <= w_head.flags;
    end
  end

  // Sticky overflow: a result was offered while the queue was full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (alu_result_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Output drive; head fields forced to zero when empty so reset shows zeros
  always_comb begin
    issue_ready = !w_full;
    wb_valid    = !w_empty;
    wb_data     = w_empty ? '0 : w_head.data;
    wb_dest     = w_empty ? '0 : w_head.dest;
    flags       = r_flags;
    count       = r_count;
    overflow    = r_overflow;
  end

endmodule

// File: tb/tb_w0rm_alu_result_queue.sv
// Scoreboard bench for w0rm_alu_result_queue: stimulus queues expected
// writebacks, a negedge monitor pops and compares them and models the flags.
module tb_w0rm_alu_result_queue;

  logic       clk;
  logic       reset;
  logic       alu_result_valid;
  logic [7:0] alu_result;
  logic [3:0] alu_result_flags;
  logic [3:0] alu_dest;
  logic       alu_flags_update;
  logic       issue_ready;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic [3:0] wb_dest;
  logic       wb_ready;
  logic [3:0] flags;
  logic [2:0] count;
  logic       overflow;

  typedef struct {
    logic [7:0] data;
    logic [3:0] dest;
    logic [3:0] flags;
    logic       upd;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  logic [3:0] exp_flags;
  int         checks;
  int         errors;

  w0rm_alu_result_queue #(
    .DATA_WIDTH(8), .REG_ADDR_WIDTH(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_result_valid(alu_result_valid), .alu_result(alu_result),
    .alu_result_flags(alu_result_flags), .alu_dest(alu_dest),
    .alu_flags_update(alu_flags_update), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_ready(wb_ready), .flags(flags), .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one result for one cycle; queue the expectation only if it should be accepted
  task automatic push(input logic [7:0] d, input logic [3:0] dst, input logic [3:0] f,
                      input logic u, input bit acc);
    exp_t e;
    alu_result_valid = 1'b1;
    alu_result       = d;
    alu_dest         = dst;
    alu_result_flags = f;
    alu_flags_update = u;
    if (acc) begin
      e.data = d; e.dest = dst; e.flags = f; e.upd = u;
      q.push_back(e);
    end
    cycle();
    alu_result_valid = 1'b0;
  endtask

  // Monitor: compare the head on every handshake, track committed flags
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_flags = 4'h0;
    end else begin
      check("flags_model", 32'(flags), 32'(exp_flags));
      if (wb_valid && wb_ready) begin
        if (q.size() == 0) begin
          check("unexpected_pop", 32'(1), 32'(0));
        end else begin
          m_e = q.pop_front();
          check("wb_data", 32'(wb_data), 32'(m_e.data));
          check("wb_dest", 32'(wb_dest), 32'(m_e.dest));
          if (m_e.upd) exp_flags = m_e.flags;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; alu_result_valid = 1'b0; alu_result = '0;
    alu_result_flags = '0; alu_dest = '0; alu_flags_update = 1'b0; wb_ready = 1'b0;
    cycle();
    check("rst_count", 32'(count), 32'(0));
    check("rst_wb_valid", 32'(wb_valid), 32'(0));
    check("rst_issue_ready", 32'(issue_ready), 32'(1));
    check("rst_flags", 32'(flags), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_wb_data", 32'(wb_data), 32'(0));
    check("rst_wb_dest", 32'(wb_dest), 32'(0));
    reset = 1'b0;

    // Single push then immediate writeback
    wb_ready = 1'b1;
    push(8'hA5, 4'd3, 4'b0100, 1'b1, 1'b1);
    check("t1_wb_valid", 32'(wb_valid), 32'(1));
    check("t1_count", 32'(count), 32'(1));
    cycle();
    check("t1_count_after", 32'(count), 32'(0));
    check("t1_wb_valid_after", 32'(wb_valid), 32'(0));
    check("t1_flags", 32'(flags), 32'(4'b0100));

    // Fill under back-pressure, then overflow
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i), 4'(i), 4'h0, 1'b0, 1'b1);
    check("t2_count_full", 32'(count), 32'(4));
    check("t2_issue_ready", 32'(issue_ready), 32'(0));
    check("t2_head_stable", 32'(wb_data), 32'(8'h01));
    push(8'h05, 4'd5, 4'h0, 1'b0, 1'b0);
    check("t2_overflow", 32'(overflow), 32'(1));
    check("t2_count_stay", 32'(count), 32'(4));

    // Full with simultaneous push and pop: pop happens, push dropped
    wb_ready = 1'b1;
    push(8'h06, 4'd6, 4'h0, 1'b0, 1'b0);
    check("t3_count", 32'(count), 32'(3));
    check("t3_overflow", 32'(overflow), 32'(1));
    repeat (3) cycle();
    check("t3_drained", 32'(count), 32'(0));

    // Flags commit only for flag-updating entries, in order
    wb_ready = 1'b0;
    push(8'h10, 4'd1, 4'h8, 1'b1, 1'b1);
    push(8'h11, 4'd2, 4'hF, 1'b0, 1'b1);
    push(8'h12, 4'd3, 4'h1, 1'b1, 1'b1);
    check("t4_flags_held", 32'(flags), 32'(4'b0100));
    wb_ready = 1'b1;
    cycle(); check("t4_flags_a", 32'(flags), 32'(4'h8));
    cycle(); check("t4_flags_b", 32'(flags), 32'(4'h8));
    cycle(); check("t4_flags_c", 32'(flags), 32'(4'h1));

    // Reset to clear sticky overflow
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t4_rst_overflow", 32'(overflow), 32'(0));
    check("t4_rst_flags", 32'(flags), 32'(0));

    // Continuous streaming across pointer wrap
    wb_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push(8'(8'h20 + i), 4'(i), 4'(i), i[0], 1'b1);
      check("t5_count", 32'(count), 32'(1));
    end
    cycle();
    check("t5_count_end", 32'(count), 32'(0));
    check("t5_overflow", 32'(overflow), 32'(0));
    check("t5_flags", 32'(flags), 32'(4'hB));

    // Asynchronous reset mid-stream
    wb_ready = 1'b0;
    push(8'h30, 4'd7, 4'h3, 1'b1, 1'b1);
    push(8'h31, 4'd8, 4'h4, 1'b1, 1'b1);
    check("t6_count_pre", 32'(count), 32'(2));
    #2;
    reset = 1'b1;
    #1;
    check("t6_count", 32'(count), 32'(0));
    check("t6_wb_valid", 32'(wb_valid), 32'(0));
    check("t6_flags", 32'(flags), 32'(0));
    check("t6_issue_ready", 32'(issue_ready), 32'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    wb_ready = 1'b1;
    push(8'h40, 4'd5, 4'h2, 1'b1, 1'b1);
    check("t6_post_valid", 32'(wb_valid), 32'(1));
    check("t6_post_data", 32'(wb_data), 32'(8'h40));
    cycle();
    check("t6_post_count", 32'(count), 32'(0));
    check("t6_post_flags", 32'(flags), 32'(4'h2));

    repeat (2) cycle();
    check("scoreboard_empty", 32'(q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/w0rm_alu_result_queue.md
# w0rm_alu_result_queue

Downstream stage of the W0RM ALU execution units (logic, shift, arithmetic). Captures each single-cycle `result_valid` pulse together with its destination register and flags, and buffers it in a small in-order FIFO. It then presents entries to register-file writeback over a valid/ready handshake. The architectural flags register is committed here, in program order, at writeback time.

## Interface
Parameters:
- DATA_WIDTH, 8, width of result data
- REG_ADDR_WIDTH, 4, width of destination register index
- FIFO_DEPTH, 4, number of entries; power of two, ≥ 2

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- alu_result_valid  input  1  one-cycle pulse: ALU result present this cycle
- alu_result  input  DATA_WIDTH  ALU result data
- alu_result_flags  input  4  ALU flags {N,Z,C,V} (bit 3..0)
- alu_dest  input  REG_ADDR_WIDTH  destination register of this result
- alu_flags_update  input  1  1 = entry commits flags at writeback
- issue_ready  output  1  queue can accept a result this cycle (not full)
- wb_valid  output  1  head entry available
- wb_data  output  DATA_WIDTH  head entry data
- wb_dest  output  REG_ADDR_WIDTH  head entry destination
- wb_ready  input  1  writeback consumes head this cycle
- flags  output  4  architectural flags register
- count  output  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  output  1  sticky: a result arrived while full

## Operation
- Storage: FIFO_DEPTH entries of {data, dest, flags, flags_update}, plus write pointer, read pointer, and occupancy counter. Pointers wrap modulo FIFO_DEPTH.
- Push: alu_result_valid && issue_ready. Writes the entry at the write pointer; the write pointer advances.
- Pop: wb_valid && wb_ready. The read pointer advances. If the popped entry has flags_update = 1, `flags` loads the entry's flags; otherwise `flags` holds.
- issue_ready = (count != FIFO_DEPTH). It is derived from registered state only, with no combinational path from wb_ready.
- wb_valid = (count != 0). wb_data and wb_dest are always the head entry. They are don't-care when wb_valid = 0, but must not change while wb_valid = 1 && wb_ready = 0.
- Push while full: the result is dropped, storage and pointers are unchanged, and overflow sets to 1. This applies even if a pop occurs in the same cycle. overflow clears only on reset.
- Simultaneous push and pop (not full, not empty): both occur and count is unchanged.
- Push into an empty queue: there is no bypass. The entry appears on wb_* the following cycle.
- Order is strictly FIFO. Results and flags commit in arrival order.

## Timing
- Reset (async assert, takes effect immediately): count = 0, pointers = 0, wb_valid = 0, issue_ready = 1, flags = 4'h0, overflow = 0, wb_data = 0, wb_dest = 0. Storage contents are not reset.
- Deassertion of reset is sampled synchronously. The first push is accepted on the first rising edge with reset low.
- Reset mid-operation discards all entries and any pending handshake. No writeback or flags commit occurs in that cycle.
- Latency: push at edge N gives wb_valid = 1 after edge N. Pop at edge M gives the `flags` update visible after edge M.
- Throughput: one push and one pop per cycle sustained.
- wb_* outputs are registered-state driven. Back-pressure via wb_ready holds the head stable indefinitely.

## Test plan
- Reset then single push (data 8'hA5, dest 3, flags 4'b0100, update 1), wb_ready = 1 → wb_valid high one cycle with A5/3; flags = 4'b0100 the cycle after the pop; count returns to 0.
- wb_ready = 0, push 4 results (8'h01..8'h04) → count = 4, issue_ready = 0. A fifth push sets overflow = 1 and count stays 4. Raising wb_ready drains 01,02,03,04 in order.
- Queue full, push and pop in the same cycle → pop of 8'h01 occurs, push dropped, overflow = 1, count = 3.
- Interleave flags_update 1,0,1 with flags 4'h8, 4'hF, 4'h1 → flags sequence after pops: 8, 8, 1.
- Continuous push and pop every cycle for 3·FIFO_DEPTH results → count stays 1 throughout, order preserved across pointer wrap, overflow = 0.
- Assert reset asynchronously mid-stream with count = 2 → immediately count = 0, wb_valid = 0, flags = 0, issue_ready = 1. The next push is delivered correctly.
